door_input_conditioner: RTL

Front-end stage for the automatic garage door controller. It conditions the raw remote push-button and the two raw limit switches before they reach the controller:
- synchronises and debounces all three inputs;
- drives clean `UP_Max`/`DN_Max` levels;
- turns each button press into a single-cycle `Activate` pulse, with a post-release lockout;
- flags the illegal both-limits-closed condition and blocks `Activate` while it holds.

---
 rtl/door_input_conditioner_if.sv | 21 ++
 rtl/door_input_conditioner.sv | 136 +++++++++++++
 2 files changed

// File: rtl/door_input_conditioner_if.sv
// Signal bundle between the garage door front-end and its environment.
// Raw switch/button levels go in; clean limit levels, the press pulse and the fault flag come out.
interface door_input_conditioner_if;
  logic Btn_Raw;
  logic Up_Sw_Raw;
  logic Dn_Sw_Raw;
  logic UP_Max;
  logic DN_Max;
  logic Activate;
  logic Fault;

  modport master (
    output Btn_Raw, Up_Sw_Raw, Dn_Sw_Raw,
    input  UP_Max, DN_Max, Activate, Fault
  );

  modport slave (
    input  Btn_Raw, Up_Sw_Raw, Dn_Sw_Raw,
    output UP_Max, DN_Max, Activate, Fault
  );
endinterface

// File: rtl/door_input_conditioner.sv
// Synchronises and debounces the button and limit switches, emits one Activate pulse per press.
// Raw edge to debounced level: 2 sync flops + DB_CYCLES; Activate one register later.
module door_input_conditioner #(
  parameter int DB_CYCLES      = 8,
  parameter int LOCKOUT_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  door_input_conditioner_if.slave   io
);

  localparam int NIN = 3;
  localparam int IDX_BTN = 0;
  localparam int IDX_UP  = 1;
  localparam int IDX_DN  = 2;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  logic [NIN-1:0]            raw;
  logic [NIN-1:0]            sync1_q;
  logic [NIN-1:0]            sync2_q;
  logic [NIN-1:0]            stable_q;
  logic [NIN-1:0]            stable_d;
  logic [NIN-1:0][CNT_W-1:0] db_cnt_q;
  logic [NIN-1:0][CNT_W-1:0] db_cnt_d;

  state_t     state_q;
  state_t     state_d;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [CNT_W-1:0] lock_cnt_d;
  logic       btn_prev_q;
  logic       activate_q;
  logic       activate_d;
  logic       fault_q;
  logic       fault_d;
  logic       db_btn;
  logic       btn_rise;

  assign raw = {io.Dn_Sw_Raw, io.Up_Sw_Raw, io.Btn_Raw};

  // Each debouncer flips only after DB_CYCLES consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < NIN; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] >= DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign db_btn   = stable_q[IDX_BTN];
  assign btn_rise = db_btn & ~btn_prev_q;
  assign fault_d  = stable_q[IDX_UP] & stable_q[IDX_DN];

  // Fault is taken from its register, so a limit fault arriving with the press edge does not block it.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    activate_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_rise) begin
          state_d    = ST_PRESSED;
          activate_d = ~fault_q;
        end
      end
      ST_PRESSED: begin
        if (!db_btn) begin
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q >= LOCK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      btn_prev_q <= 1'b0;
      activate_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      btn_prev_q <= db_btn;
      activate_q <= activate_d;
      fault_q    <= fault_d;
    end
  end

  assign io.UP_Max   = stable_q[IDX_UP];
  assign io.DN_Max   = stable_q[IDX_DN];
  assign io.Activate = activate_q;
  assign io.Fault    = fault_q;

endmodule
